// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback, multi-cycle result and register-file write port signals
interface regfile_wb_arbiter_if #(parameter int XLEN = 32, parameter int AW = 5);
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_stall;
  logic            mc_valid;
  logic [AW-1:0]   mc_rd;
  logic [XLEN-1:0] mc_data;
  logic            mc_ready;
  logic            rf_en;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_data;
  modport master (
    output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
    input  wb_stall, mc_ready, rf_en, rf_rd, rf_data
  );
  modport slave (
    input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
    output wb_stall, mc_ready, rf_en, rf_rd, rf_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between writeback and a multi-cycle result FIFO
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [AW-1:0]   mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [WW-1:0]   wait_cnt;
  logic            live, wb_req, have, force_drain, deq, enq;
  // live holds mc_ready low until the first edge after reset release
  always_comb begin
    wb_req       = rst && bus.wb_valid && bus.wb_rd != '0;
    have         = count != '0;
    force_drain  = have && (count == CW'(DEPTH) || wait_cnt == WW'(MAX_WAIT));
    deq          = have && (!wb_req || force_drain);
    bus.mc_ready = live && count != CW'(DEPTH);
    enq          = bus.mc_valid && bus.mc_ready && bus.mc_rd != '0;
    bus.rf_en    = deq || wb_req;
    bus.wb_stall = deq && wb_req;
    bus.rf_rd    = (wb_req && !deq) ? bus.wb_rd : have ? mem_rd[rd_ptr] : '0;
    bus.rf_data  = (wb_req && !deq) ? bus.wb_data : have ? mem_data[rd_ptr] : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      live     <= 1'b1;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(enq) - CW'(deq);
      wait_cnt <= (deq || !have) ? '0 : (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_rd[wr_ptr]   <= bus.mc_rd;
      mem_data[wr_ptr] <= bus.mc_data;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of writeback, drain, starvation, full and reset behaviour
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  regfile_wb_arbiter_if #(.XLEN(32), .AW(5)) bus();
  regfile_wb_arbiter #(.XLEN(32), .AW(5), .DEPTH(2), .MAX_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mc(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.mc_valid = v;
    bus.mc_rd    = rd;
    bus.mc_data  = d;
  endtask
  task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
    bus.wb_data  = d;
  endtask
  initial begin
    wb(1'b1, 5'd5, 32'h1111_1111);
    mc(1'b1, 5'd1, 32'h2222_2222);
    repeat (2) @(posedge clk);
    #2;
    check("rst_rf_en", 64'(bus.rf_en), 64'd0);
    check("rst_stall", 64'(bus.wb_stall), 64'd0);
    check("rst_ready", 64'(bus.mc_ready), 64'd0);
    check("rst_rf_rd", 64'(bus.rf_rd), 64'd0);
    check("rst_rf_data", 64'(bus.rf_data), 64'd0);
    wb(1'b0, 5'd0, 32'd0);
    mc(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_ready_low", 64'(bus.mc_ready), 64'd0);
    tick();
    check("rel_ready_high", 64'(bus.mc_ready), 64'd1);
    wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    check("wb_en", 64'(bus.rf_en), 64'd1);
    check("wb_rd", 64'(bus.rf_rd), 64'd5);
    check("wb_data", 64'(bus.rf_data), 64'hDEAD_BEEF);
    check("wb_stall", 64'(bus.wb_stall), 64'd0);
    wb(1'b1, 5'd0, 32'hDEAD_BEEF);
    #1;
    check("wb_x0_en", 64'(bus.rf_en), 64'd0);
    check("wb_x0_stall", 64'(bus.wb_stall), 64'd0);
    wb(1'b0, 5'd0, 32'd0);
    mc(1'b1, 5'd7, 32'h0000_1234);
    #1;
    check("mc_nobypass", 64'(bus.rf_en), 64'd0);
    tick();
    mc(1'b0, 5'd0, 32'd0);
    check("mc_en", 64'(bus.rf_en), 64'd1);
    check("mc_rd", 64'(bus.rf_rd), 64'd7);
    check("mc_data", 64'(bus.rf_data), 64'h1234);
    tick();
    check("mc_done", 64'(bus.rf_en), 64'd0);
    mc(1'b1, 5'd9, 32'hA5A5_A5A5);
    tick();
    mc(1'b0, 5'd0, 32'd0);
    wb(1'b1, 5'd3, 32'h3333_3333);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("starve_wb_rd%0d", i), 64'(bus.rf_rd), 64'd3);
      check($sformatf("starve_wb_stall%0d", i), 64'(bus.wb_stall), 64'd0);
      tick();
    end
    check("starve_rd", 64'(bus.rf_rd), 64'd9);
    check("starve_data", 64'(bus.rf_data), 64'hA5A5_A5A5);
    check("starve_stall", 64'(bus.wb_stall), 64'd1);
    tick();
    check("starve_after_rd", 64'(bus.rf_rd), 64'd3);
    check("starve_after_stall", 64'(bus.wb_stall), 64'd0);
    mc(1'b1, 5'd10, 32'h0000_000A);
    #1;
    check("full_ready0", 64'(bus.mc_ready), 64'd1);
    tick();
    mc(1'b1, 5'd11, 32'h0000_000B);
    #1;
    check("full_ready1", 64'(bus.mc_ready), 64'd1);
    check("full_wb_rd1", 64'(bus.rf_rd), 64'd3);
    tick();
    mc(1'b0, 5'd0, 32'd0);
    check("full_ready", 64'(bus.mc_ready), 64'd0);
    check("full_stall", 64'(bus.wb_stall), 64'd1);
    check("full_rd", 64'(bus.rf_rd), 64'd10);
    tick();
    check("full_ready_back", 64'(bus.mc_ready), 64'd1);
    check("full_next_stall", 64'(bus.wb_stall), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_wb_rd_c%0d", i), 64'(bus.rf_rd), 64'd3);
      tick();
    end
    check("full_second_rd", 64'(bus.rf_rd), 64'd11);
    check("full_second_stall", 64'(bus.wb_stall), 64'd1);
    tick();
    check("full_drained_stall", 64'(bus.wb_stall), 64'd0);
    wb(1'b0, 5'd0, 32'd0);
    #1;
    check("full_drained_en", 64'(bus.rf_en), 64'd0);
    mc(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    mc(1'b0, 5'd0, 32'd0);
    check("x0_ready", 64'(bus.mc_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("x0_no_write%0d", i), 64'(bus.rf_en), 64'd0);
      tick();
    end
    wb(1'b1, 5'd3, 32'h3333_3333);
    mc(1'b1, 5'd12, 32'h0000_000C);
    tick();
    mc(1'b0, 5'd0, 32'd0);
    check("midrst_held", 64'(bus.rf_rd), 64'd3);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("midrst_en", 64'(bus.rf_en), 64'd0);
    check("midrst_ready", 64'(bus.mc_ready), 64'd0);
    #2;
    rst = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    tick();
    check("midrst_ready_after", 64'(bus.mc_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("midrst_dropped%0d", i), 64'(bus.rf_en), 64'd0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
